hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage 8-bit core (3-bit register addresses, 12-bit PC).
- Drives the write-enable and flush controls of PC, IF/ID and ID/EXE, plus the EXE/MEM hold.
- Produces the EXE operand-forwarding selects.
- Sequences the multi-cycle branch-redirect window and the memory-busy freeze.
- Keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side drives hazard inputs; the controller drives enables, flushes and forwarding selects.
interface hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_useRs;
    logic        id_useRt;
    logic [2:0]  exe_rd;
    logic        exe_regWr;
    logic        exe_memRd;
    logic        exe_brTaken;
    logic [2:0]  mem_rd;
    logic        mem_regWr;
    logic        mem_busy;

    logic        pcWr;
    logic        ifIdWr;
    logic        ifIdFlush;
    logic        idExeFlush;
    logic        exeMemWr;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        state;
    logic [15:0] stallCnt;

    modport master (
        output id_rs, id_rt, id_useRs, id_useRt,
        output exe_rd, exe_regWr, exe_memRd, exe_brTaken,
        output mem_rd, mem_regWr, mem_busy,
        input  pcWr, ifIdWr, ifIdFlush, idExeFlush, exeMemWr,
        input  fwdA, fwdB, state, stallCnt
    );

    modport slave (
        input  id_rs, id_rt, id_useRs, id_useRt,
        input  exe_rd, exe_regWr, exe_memRd, exe_brTaken,
        input  mem_rd, mem_regWr, mem_busy,
        output pcWr, ifIdWr, ifIdFlush, idExeFlush, exeMemWr,
        output fwdA, fwdB, state, stallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage 8-bit core: forwarding selects,
// load-use stall, multi-cycle branch flush window, memory freeze and a stall-cycle counter.
module hazard_ctrl #(
    parameter int BR_PENALTY   = 1,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  fcnt_reg, fcnt_next;
    logic [15:0] stall_cnt_reg, stall_cnt_next;
    logic [15:0] stall_cnt_inc;

    logic             exe_fwd_ok;
    logic             mem_fwd_ok;
    logic [1:0][2:0]  src;
    logic [1:0]       use_src;
    logic [1:0][1:0]  fwd_sel;
    logic [1:0]       src_hazard;
    logic             load_use;

    logic pc_wr, if_id_wr, if_id_flush, id_exe_flush, exe_mem_wr;

    // A write to r0 is discarded when it is hardwired, so it can never be a producer.
    assign exe_fwd_ok = bus.exe_regWr && !(R0_HARDWIRED && (bus.exe_rd == 3'd0));
    assign mem_fwd_ok = bus.mem_regWr && !(R0_HARDWIRED && (bus.mem_rd == 3'd0));

    assign src[0]     = bus.id_rs;
    assign src[1]     = bus.id_rt;
    assign use_src[0] = bus.id_useRs;
    assign use_src[1] = bus.id_useRt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            // The younger producer in EXE wins over the older one in MEM.
            assign fwd_sel[gi] = (exe_fwd_ok && (bus.exe_rd == src[gi])) ? 2'b01 :
                                 (mem_fwd_ok && (bus.mem_rd == src[gi])) ? 2'b10 : 2'b00;
            assign src_hazard[gi] = use_src[gi] && exe_fwd_ok && bus.exe_memRd &&
                                    (bus.exe_rd == src[gi]);
        end
    endgenerate

    assign load_use      = |src_hazard;
    assign stall_cnt_inc = (stall_cnt_reg == 16'hFFFF) ? stall_cnt_reg : stall_cnt_reg + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            fcnt_reg      <= 3'd0;
            stall_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            fcnt_reg      <= fcnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        fcnt_next      = fcnt_reg;
        stall_cnt_next = stall_cnt_reg;
        if (bus.mem_busy) begin
            stall_cnt_next = stall_cnt_inc;
        end else if (bus.exe_brTaken) begin
            if (BR_PENALTY > 1) begin
                state_next = FLUSH;
                fcnt_next  = 3'(BR_PENALTY - 1);
            end else begin
                state_next = RUN;
                fcnt_next  = 3'd0;
            end
        end else if (state_reg == FLUSH) begin
            // The flush cycle that sees fcnt==1 is the last one of the window.
            if (fcnt_reg <= 3'd1) begin
                state_next = RUN;
                fcnt_next  = 3'd0;
            end else begin
                fcnt_next  = fcnt_reg - 3'd1;
            end
        end else if (load_use) begin
            stall_cnt_next = stall_cnt_inc;
        end
    end

    always_comb begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        exe_mem_wr   = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (rst) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            exe_mem_wr   = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (bus.mem_busy) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            exe_mem_wr   = 1'b0;
        end else if (bus.exe_brTaken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (state_reg == FLUSH) begin
            if_id_flush  = 1'b1;
        end else if (load_use) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_exe_flush = 1'b1;
        end
    end

    assign bus.pcWr       = pc_wr;
    assign bus.ifIdWr     = if_id_wr;
    assign bus.exeMemWr   = exe_mem_wr;
    assign bus.ifIdFlush  = if_id_flush;
    assign bus.idExeFlush = id_exe_flush;
    assign bus.fwdA       = rst ? 2'b00 : fwd_sel[0];
    assign bus.fwdB       = rst ? 2'b00 : fwd_sel[1];
    assign bus.state      = state_reg;
    assign bus.stallCnt   = stall_cnt_reg;

endmodule
